// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter sharing one UART transmit byte stream between N requesters.
// Packets stay contiguous; a stalled owner loses its grant after IDLE_TIMEOUT idle cycles.
module uart_tx_arb #(
    parameter int unsigned N            = 2,
    parameter int unsigned IDLE_TIMEOUT = 4800
) (
    input  logic           clk_48_i,
    input  logic           rst_ni,
    input  logic [8*N-1:0] s_data_i,
    input  logic [N-1:0]   s_valid_i,
    input  logic [N-1:0]   s_last_i,
    output logic [N-1:0]   s_ready_o,
    output logic [7:0]     m_data_o,
    output logic           m_valid_o,
    input  logic           m_ready_i,
    output logic [N-1:0]   grant_o,
    output logic           busy_o,
    output logic           timeout_o
);

    localparam int unsigned   PtrW  = $clog2(N);
    localparam int unsigned   TW    = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLast = (IDLE_TIMEOUT > 0) ? TW'(IDLE_TIMEOUT - 1) : '0;
    localparam logic [TW-1:0] TMax  = {TW{1'b1}};

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [N-1:0]    owner_q, owner_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            timeout_q, timeout_d;

    logic            own_valid, own_last, xfer;
    logic [7:0]      own_data;
    logic [PtrW-1:0] ptr_rel;
    logic [N-1:0]    sel_oh;
    logic            sel_found;

    always_ff @(posedge clk_48_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            owner_q   <= '0;
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Owner's lane and the pointer value that follows it.
    always_comb begin
        own_valid = |(s_valid_i & owner_q);
        own_last  = |(s_last_i & owner_q);
        own_data  = '0;
        ptr_rel   = '0;
        for (int i = 0; i < N; i++) begin
            if (owner_q[i]) begin
                own_data = s_data_i[8*i +: 8];
                ptr_rel  = PtrW'((i + 1) % N);
            end
        end
    end

    // First requester at or after ptr_q, wrapping.
    always_comb begin
        sel_oh    = '0;
        sel_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!sel_found && s_valid_i[i] && (i == (int'(ptr_q) + k) % N)) begin
                    sel_found = 1'b1;
                    sel_oh[i] = 1'b1;
                end
            end
        end
    end

    assign xfer = own_valid & m_ready_i;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        tcnt_d    = tcnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    owner_d = sel_oh;
                    tcnt_d  = '0;
                    state_d = StOwn;
                end
            end
            StOwn: begin
                if (xfer) begin
                    tcnt_d = '0;
                    if (own_last) begin
                        state_d = StIdle;
                        owner_d = '0;
                        ptr_d   = ptr_rel;
                    end
                end else if (IDLE_TIMEOUT > 0 && !own_valid) begin
                    // Backpressure with valid held is not idle, so only a low valid counts.
                    if (tcnt_q == TLast) begin
                        state_d   = StIdle;
                        owner_d   = '0;
                        ptr_d     = ptr_rel;
                        timeout_d = 1'b1;
                    end else if (tcnt_q != TMax) begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are forced quiet during reset even though owner_q clears only at the edge.
    always_comb begin
        grant_o   = '0;
        busy_o    = 1'b0;
        timeout_o = 1'b0;
        m_data_o  = '0;
        m_valid_o = 1'b0;
        s_ready_o = '0;
        if (rst_ni) begin
            grant_o   = owner_q;
            busy_o    = (state_q == StOwn);
            timeout_o = timeout_q;
            if (state_q == StOwn) begin
                m_data_o  = own_data;
                m_valid_o = own_valid;
                s_ready_o = owner_q & {N{m_ready_i}};
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: scoreboarded byte stream on an N=2 instance, table-driven
// round-robin vectors on an N=4 instance, plus hand sequences for stall, backpressure and reset.
module tb_uart_tx_arb;

    typedef struct {
        int unsigned src;
        logic [7:0]  data;
    } exp_t;

    typedef struct {
        int unsigned prev;
        logic [3:0]  req;
        logic [3:0]  exp_gnt;
    } arb_vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] s_data_a;
    logic [1:0]  s_valid_a, s_last_a, s_ready_a, grant_a;
    logic [7:0]  m_data_a;
    logic        m_valid_a, m_ready_a, busy_a, timeout_a;
    logic [31:0] s_data_b;
    logic [3:0]  s_valid_b, s_last_b, s_ready_b, grant_b;
    logic [7:0]  m_data_b;
    logic        m_valid_b, m_ready_b, busy_b, timeout_b;

    // Staged inputs, applied just after each rising edge.
    logic        n_rst, n_mready;
    logic [1:0]  en;
    logic [3:0]  nb_valid, nb_last;
    logic        nb_mready;

    logic [8:0]  rq0[$];
    logic [8:0]  rq1[$];
    exp_t        exp_q[$];
    logic        xfer_last;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    uart_tx_arb #(.N(2), .IDLE_TIMEOUT(4800)) u_dut_a (
        .clk_48_i (clk),
        .rst_ni   (rst_n),
        .s_data_i (s_data_a),
        .s_valid_i(s_valid_a),
        .s_last_i (s_last_a),
        .s_ready_o(s_ready_a),
        .m_data_o (m_data_a),
        .m_valid_o(m_valid_a),
        .m_ready_i(m_ready_a),
        .grant_o  (grant_a),
        .busy_o   (busy_a),
        .timeout_o(timeout_a)
    );

    uart_tx_arb #(.N(4), .IDLE_TIMEOUT(4800)) u_dut_b (
        .clk_48_i (clk),
        .rst_ni   (rst_n),
        .s_data_i (s_data_b),
        .s_valid_i(s_valid_b),
        .s_last_i (s_last_b),
        .s_ready_o(s_ready_b),
        .m_data_o (m_data_b),
        .m_valid_o(m_valid_b),
        .m_ready_i(m_ready_b),
        .grant_o  (grant_b),
        .busy_o   (busy_b),
        .timeout_o(timeout_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic load(input int src, input logic [7:0] d, input logic last, input logic ex);
        exp_t e;
        if (src == 0) rq0.push_back({last, d});
        else          rq1.push_back({last, d});
        if (ex) begin
            e.src  = src;
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = n_rst;
        m_ready_a = n_mready;
        s_valid_a = '0;
        s_last_a  = '0;
        s_data_a  = '0;
        if (en[0] && rq0.size() > 0) begin
            s_valid_a[0]   = 1'b1;
            s_data_a[7:0]  = rq0[0][7:0];
            s_last_a[0]    = rq0[0][8];
        end
        if (en[1] && rq1.size() > 0) begin
            s_valid_a[1]   = 1'b1;
            s_data_a[15:8] = rq1[0][7:0];
            s_last_a[1]    = rq1[0][8];
        end
        s_valid_b = nb_valid;
        s_last_b  = nb_last;
        m_ready_b = nb_mready;
        @(negedge clk);
        xfer_last = 1'b0;
        if (m_valid_a && m_ready_a) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected_byte: got %02h, required no transfer", m_data_a);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", m_data_a, e.data);
                check("sb_src_grant", grant_a, 32'(1) << e.src);
            end
        end
        if (s_valid_a[0] && s_ready_a[0]) begin
            xfer_last = xfer_last | rq0[0][8];
            void'(rq0.pop_front());
        end
        if (s_valid_a[1] && s_ready_a[1]) begin
            xfer_last = xfer_last | rq1[0][8];
            void'(rq1.pop_front());
        end
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required end before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        arb_vec_t vecs[7];
        int       since, bad, found;
        vecs[0] = '{3, 4'b0101, 4'b0001};  // wrap past the end to requester 0
        vecs[1] = '{0, 4'b1111, 4'b0010};
        vecs[2] = '{1, 4'b0011, 4'b0001};
        vecs[3] = '{2, 4'b1001, 4'b1000};
        vecs[4] = '{1, 4'b1100, 4'b0100};
        vecs[5] = '{3, 4'b1110, 4'b0010};
        vecs[6] = '{0, 4'b0001, 4'b0001};

        rst_n = 1'b0; m_ready_a = 1'b0; s_valid_a = '0; s_last_a = '0; s_data_a = '0;
        s_valid_b = '0; s_last_b = '0; m_ready_b = 1'b0; s_data_b = 32'h33221100;
        n_rst = 1'b0; n_mready = 1'b1; en = 2'b11;
        nb_valid = '0; nb_last = '0; nb_mready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_grant", grant_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_m_valid", m_valid_a, 0);
        check("rst_s_ready", s_ready_a, 0);
        check("rst_timeout", timeout_a, 0);
        check("rst_m_data", m_data_a, 0);
        n_rst = 1'b1;

        // Single requester, 3-byte packet
        load(0, 8'h41, 1'b0, 1'b1);
        load(0, 8'h42, 1'b0, 1'b1);
        load(0, 8'h43, 1'b1, 1'b1);
        tick();
        check("single_sel_cycle_busy", busy_a, 0);
        tick();
        check("single_grant", grant_a, 2'b01);
        check("single_s_ready", s_ready_a, 2'b01);
        tick();
        tick();
        check("single_grant_last", grant_a, 2'b01);
        tick();
        check("single_busy_drop", busy_a, 0);
        check("single_grant_drop", grant_a, 0);
        // ptr is now 1: requester 1 must win a simultaneous request
        load(1, 8'h60, 1'b1, 1'b1);
        load(0, 8'h50, 1'b1, 1'b1);
        tick();
        tick();
        check("ptr_after_single", grant_a, 2'b10);
        check("nonowner_ignored", s_ready_a[0], 0);
        repeat (4) tick();
        check("single_drained", exp_q.size(), 0);

        // Contention from reset, 2-byte packets
        do_reset();
        load(0, 8'h01, 1'b0, 1'b1); load(0, 8'h02, 1'b1, 1'b1);
        load(1, 8'h11, 1'b0, 1'b1); load(1, 8'h12, 1'b1, 1'b1);
        load(0, 8'h03, 1'b0, 1'b1); load(0, 8'h04, 1'b1, 1'b1);
        load(1, 8'h13, 1'b0, 1'b1); load(1, 8'h14, 1'b1, 1'b1);
        since = 99;
        for (int c = 0; c < 16; c++) begin
            tick();
            since++;
            if (grant_a == 2'b01) check("ct_s_ready1_quiet", s_ready_a[1], 0);
            if (since == 1) check("ct_gap_idle", busy_a, 0);
            if (since == 2 && exp_q.size() > 0) check("ct_next_grant", busy_a, 1);
            if (xfer_last) since = 0;
        end
        check("ct_drained", exp_q.size(), 0);

        // Backpressure for 20000 cycles: no timeout, byte neither lost nor duplicated
        do_reset();
        load(0, 8'hA5, 1'b0, 1'b1);
        load(0, 8'hA6, 1'b1, 1'b1);
        n_mready = 1'b0;
        tick();
        tick();
        check("bp_grant", grant_a, 2'b01);
        check("bp_m_valid", m_valid_a, 1);
        check("bp_s_ready", s_ready_a, 0);
        bad = 0;
        repeat (20000) begin
            tick();
            if (timeout_a || grant_a != 2'b01 || !m_valid_a || m_data_a != 8'hA5) bad++;
        end
        check("bp_bad_cycles", bad, 0);
        n_mready = 1'b1;
        repeat (4) tick();
        check("bp_drained", exp_q.size(), 0);
        check("bp_rq0_empty", rq0.size(), 0);

        // Stall timeout with the other requester waiting
        do_reset();
        load(0, 8'h71, 1'b0, 1'b1);
        load(1, 8'h81, 1'b1, 1'b1);
        load(0, 8'h72, 1'b1, 1'b1);
        tick();
        tick();
        check("to_first_grant", grant_a, 2'b01);
        en = 2'b10;
        found = 0;
        for (int k = 1; k <= 6000 && found == 0; k++) begin
            tick();
            if (timeout_a) begin
                found = 1;
                check("to_delay", k, 4801);
                check("to_grant_drop", grant_a, 0);
            end
        end
        check("to_seen", found, 1);
        tick();
        check("to_pulse_width", timeout_a, 0);
        check("to_next_grant", grant_a, 2'b10);
        en = 2'b11;
        repeat (5) tick();
        check("to_drained", exp_q.size(), 0);

        // Reset mid-packet while requester 1 owns with ptr=1
        do_reset();
        load(0, 8'h30, 1'b1, 1'b1);
        load(1, 8'h31, 1'b0, 1'b1);
        load(1, 8'h32, 1'b0, 1'b1);
        load(1, 8'h33, 1'b0, 1'b0);
        load(1, 8'h34, 1'b1, 1'b0);
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick();
        check("rm_pre_drained", exp_q.size(), 0);
        n_rst = 1'b0;
        tick();
        check("rm_grant", grant_a, 0);
        check("rm_m_valid", m_valid_a, 0);
        check("rm_s_ready", s_ready_a, 0);
        rq1.delete();
        load(0, 8'h91, 1'b1, 1'b1);
        load(1, 8'h92, 1'b1, 1'b1);
        n_rst = 1'b1;
        tick();
        check("rm_after_busy", busy_a, 0);
        check("rm_after_m_valid", m_valid_a, 0);
        tick();
        check("rm_ptr_zero_win", grant_a, 2'b01);
        repeat (4) tick();
        check("rm_drained", exp_q.size(), 0);

        // Table-driven round-robin vectors on the N=4 instance
        for (int v = 0; v < 7; v++) begin
            nb_valid = '0;
            nb_mready = 1'b0;
            do_reset();
            nb_valid  = 4'(32'(1) << vecs[v].prev);
            nb_last   = 4'hF;
            nb_mready = 1'b1;
            tick();
            tick();
            check("vec_setup_grant", grant_b, 32'(1) << vecs[v].prev);
            check("vec_setup_data", m_data_b, 32'h11 * vecs[v].prev);
            check("vec_setup_valid", m_valid_b, 1);
            nb_valid  = vecs[v].req;
            nb_mready = 1'b0;
            tick();
            check("vec_gap_idle", busy_b, 0);
            tick();
            check("vec_grant", grant_b, vecs[v].exp_gnt);
            check("vec_s_ready", s_ready_b, 0);
            check("vec_timeout", timeout_b, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Packet-level round-robin arbiter that shares the single UART transmit byte stream between N requesters (e.g. the command-response engine and the asynchronous event reporter). It sits between the requesters and the UART's `tx_data`/`tx_data_valid`/`tx_data_ready` handshake. It keeps a granted requester's packet contiguous on the wire, and it reclaims the grant if that requester stalls mid-packet.

## Interface
- `N`, 2, number of requesters (2..8).
- `IDLE_TIMEOUT`, 4800, cycles a granted requester may hold `s_valid` low mid-packet before its grant is revoked (100 µs at 48 MHz). 0 disables the timeout.

- `clk_48` in 1: sole clock; all state on its rising edge.
- `rst` in 1: synchronous, active-low reset (asserted when 0).
- `s_data` in 8*N: requester bytes; requester i occupies bits [8i+7:8i].
- `s_valid` in N: requester i has a byte.
- `s_last` in N: requester i's byte is the last of its packet.
- `s_ready` out N: byte of requester i accepted this cycle when `s_valid[i]` is also high.
- `m_data` out 8: byte toward UART `tx_data`.
- `m_valid` out 1: toward UART `tx_data_valid`.
- `m_ready` in 1: from UART `tx_data_ready`.
- `grant` out N: one-hot current owner; all zero when idle.
- `busy` out 1: a grant is held.
- `timeout` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- **State register.** Two states, IDLE and OWN, plus:
  - `ptr`: round-robin start index, width clog2(N).
  - `owner`: registered one-hot grant.
  - `tcnt`: idle counter, width clog2(IDLE_TIMEOUT+1).
- **IDLE.**
  - `grant`=0, `m_valid`=0, `s_ready`=0.
  - If any `s_valid` is high, select the first i with `s_valid[i]`=1, searching ptr, ptr+1, …, N-1, 0, …, wrapping modulo N.
  - Register `owner`=one-hot(i), clear `tcnt`, go to OWN.
  - No byte is transferred in the selection cycle.
- **OWN (owner g).** Combinational passthrough:
  - `m_data`=`s_data[g]`, `m_valid`=`s_valid[g]`.
  - `s_ready[g]`=`m_ready`; `s_ready` of every other requester is 0.
  - Non-owners are ignored regardless of `s_valid`.
- **Handshake.** A transfer occurs when `s_valid[g]` and `m_ready` are both high.
  - Every transfer clears `tcnt`.
  - A transfer with `s_last[g]`=1 releases the grant: go to IDLE, `ptr` ← (g+1) mod N.
- **Timeout.** Applies only when IDLE_TIMEOUT>0.
  - In OWN with `s_valid[g]`=0, `tcnt` increments and saturates.
  - When `tcnt` = IDLE_TIMEOUT-1 and `s_valid[g]` is still 0, release as for a last byte: go to IDLE, `ptr` ← (g+1) mod N, `timeout`=1 for the following cycle.
  - `s_valid[g]`=1 with `m_ready`=0 (UART backpressure) is not idle; `tcnt` holds.
- **Packet shape.**
  - A single-byte packet (`s_last` on the first byte) is legal.
  - `s_last` is sampled only on transfer cycles.
- **Reset (`rst`=0).** Overrides everything, including mid-packet.
  - State=IDLE, `ptr`=0, `owner`=0, `tcnt`=0.
  - Outputs: `grant`=0, `busy`=0, `m_valid`=0, `s_ready`=0, `timeout`=0. `m_data` is don't-care (drive 0).
  - A partially sent packet is abandoned; no byte is transferred during reset.

## Timing
- Arbitration latency: `s_valid[i]` rising in IDLE gives `grant[i]`=1 on the next cycle. The first byte can transfer that same cycle if `m_ready`=1.
- Inter-packet gap: the transfer of the last byte is followed by exactly one IDLE cycle, then the next owner's grant. A lone requester therefore sends back-to-back packets with a 1-cycle bubble.
- `busy` = (state==OWN); `grant` = `owner` registered; both update one cycle after the deciding event.
- `m_valid`, `m_data` and `s_ready` are combinational from inputs and the registered owner. There is no combinational path from `s_valid` to `s_ready`.
- Timeout release:
  - The grant drops at the edge that follows the cycle with `tcnt`=IDLE_TIMEOUT-1, i.e. IDLE_TIMEOUT cycles after the last transfer or grant with `s_valid` low.
  - `timeout` is high for exactly the first IDLE cycle.
- Simultaneous requests resolve strictly by `ptr` order. Fairness: a continuously requesting requester waits at most N-1 packets.

## Test plan
- **Single requester.** N=2; requester 0 sends 3 bytes 0x41,0x42,0x43 with `s_last` on 0x43, `m_ready`=1 → `grant`=01 one cycle after `s_valid`; `m_data` sequence 41,42,43 on consecutive cycles; `busy` drops the cycle after 0x43; `ptr`=1.
- **Contention.** Both requesters request from reset with 2-byte packets, continuously → wire order is pkt0, pkt1, pkt0, pkt1…. `s_ready[1]`=0 throughout every requester-0 packet. One IDLE cycle between packets.
- **Backpressure.** `m_ready` is held low for 20000 cycles while the owner holds `s_valid`=1, with IDLE_TIMEOUT=4800 → no timeout; the grant is held and the byte is not duplicated or lost when `m_ready` returns.
- **Stall timeout.** The owner sends 1 byte without `s_last`, then `s_valid`=0; the other requester is waiting → `timeout` pulses 4800 cycles after that transfer, and the other requester is granted on the next cycle.
- **Reset mid-packet.** `rst`=0 for one cycle after the 2nd of 4 bytes → the next cycle shows `grant`=0, `m_valid`=0, `ptr`=0. Afterwards requester 0 wins a simultaneous request.
- **Wrap-around.** N=4; the last owner is requester 3 and requesters 0 and 2 are pending → requester 0 is granted.
